// File: rtl/mem_pkg.sv
// Shared definitions for the 512-byte big-endian memory responder:
// size encodings, FSM state encoding, memory depth and lane helpers.
package mem_pkg;

    localparam int MEM_DEPTH = 512;
    localparam int ADDR_W    = 9;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Misaligned halfword/word or reserved size is a fault.
    function automatic logic is_fault(input logic [1:0] size, input logic [ADDR_W-1:0] addr);
        case (size)
            SZ_BYTE: is_fault = 1'b0;
            SZ_HALF: is_fault = addr[0];
            SZ_WORD: is_fault = (addr[1:0] != 2'b00);
            default: is_fault = 1'b1;
        endcase
    endfunction

    // Lane 0 (bit 3) is the byte at the base address, i.e. the MSB.
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_mask = 4'b1000;
            SZ_HALF: lane_mask = 4'b1100;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Moves right-justified write data up to the lanes starting at the base.
    function automatic logic [31:0] align_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: align_wdata = {data[7:0], 24'h000000};
            SZ_HALF: align_wdata = {data[15:0], 16'h0000};
            SZ_WORD: align_wdata = data;
            default: align_wdata = 32'h00000000;
        endcase
    endfunction

    // Right-justifies and zero-extends lane data for the access size.
    function automatic logic [31:0] extract_rdata(input logic [1:0] size, input logic [31:0] lanes);
        case (size)
            SZ_BYTE: extract_rdata = {24'h000000, lanes[31:24]};
            SZ_HALF: extract_rdata = {16'h0000, lanes[31:16]};
            SZ_WORD: extract_rdata = lanes;
            default: extract_rdata = 32'h00000000;
        endcase
    endfunction

endpackage

// File: rtl/byte_ram512.sv
// 512x8 byte array, synchronous write / asynchronous read, exposing four
// consecutive byte lanes starting at a base address (lane 0 = MSB).
module byte_ram512
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              we,
    input  logic [3:0]        lane_en,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0]        mem_r [0:MEM_DEPTH-1];
    logic [ADDR_W-1:0] lane_addr_s [4];

    // Lane addresses; the top lanes may wrap past 511 but are then never enabled.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr_s[k] = base_addr + ADDR_W'(k);
        end
    end

    // Byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we && lane_en[3-k]) begin
                mem_r[lane_addr_s[k]] <= wdata[31-8*k -: 8];
            end
        end
    end

    // Combinational lane read.
    always_comb begin
        rdata = 32'h00000000;
        for (int k = 0; k < 4; k++) begin
            rdata[31-8*k -: 8] = mem_r[lane_addr_s[k]];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Four-phase memory responder: captures a request, waits WAIT_STATES cycles,
// performs one big-endian byte/half/word access and holds the result until mov drops.
module mem_responder
    import mem_pkg::*;
#(
    parameter int WAIT_STATES = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mov,
    input  logic        rw,
    input  logic [8:0]  addr,
    input  logic [1:0]  size,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        moc,
    output logic        err
);

    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic        cap_s;
    logic        rw_r;
    logic [8:0]  addr_r;
    logic [1:0]  size_r;
    logic [31:0] wdata_r;
    logic        moc_r, moc_nxt_s;
    logic        err_r, err_nxt_s;
    logic [31:0] data_out_r, data_out_nxt_s;
    logic        fault_s;
    logic        we_s;
    logic [31:0] lanes_s;

    assign fault_s = is_fault(size_r, addr_r);

    byte_ram512 u_ram (
        .clk       (clk),
        .base_addr (addr_r),
        .we        (we_s),
        .lane_en   (lane_mask(size_r)),
        .wdata     (align_wdata(size_r, wdata_r)),
        .rdata     (lanes_s)
    );

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        cap_s          = 1'b0;
        we_s           = 1'b0;
        moc_nxt_s      = moc_r;
        err_nxt_s      = err_r;
        data_out_nxt_s = data_out_r;
        case (state_r)
            ST_IDLE: begin
                if (mov) begin
                    cap_s     = 1'b1;
                    cnt_nxt_s = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_nxt_s = ST_ACCESS;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!mov) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_ACCESS: begin
                // Committed regardless of mov so a late drop still completes.
                state_nxt_s = ST_DONE;
                moc_nxt_s   = 1'b1;
                if (fault_s) begin
                    err_nxt_s      = 1'b1;
                    data_out_nxt_s = 32'h00000000;
                end else begin
                    err_nxt_s      = 1'b0;
                    we_s           = ~rw_r;
                    data_out_nxt_s = rw_r ? extract_rdata(size_r, lanes_s) : 32'h00000000;
                end
            end
            ST_DONE: begin
                if (!mov) begin
                    state_nxt_s    = ST_IDLE;
                    moc_nxt_s      = 1'b0;
                    err_nxt_s      = 1'b0;
                    data_out_nxt_s = 32'h00000000;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                cnt_nxt_s      = 4'd0;
                moc_nxt_s      = 1'b0;
                err_nxt_s      = 1'b0;
                data_out_nxt_s = 32'h00000000;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            moc_r      <= 1'b0;
            err_r      <= 1'b0;
            data_out_r <= 32'h00000000;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            moc_r      <= moc_nxt_s;
            err_r      <= err_nxt_s;
            data_out_r <= data_out_nxt_s;
        end
    end

    // Request capture; only loaded in IDLE so later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_r    <= 1'b0;
            addr_r  <= 9'h000;
            size_r  <= SZ_BYTE;
            wdata_r <= 32'h00000000;
        end else if (cap_s) begin
            rw_r    <= rw;
            addr_r  <= addr;
            size_r  <= size;
            wdata_r <= data_in;
        end
    end

    assign data_out = data_out_r;
    assign moc      = moc_r;
    assign err      = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (WAIT_STATES=2) against a byte-array
// model of the big-endian memory.
module tb_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mov;
    logic        rw;
    logic [8:0]  addr;
    logic [1:0]  size;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        moc;
    logic        err;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t       sb_q [$];
    logic [7:0] model_mem [0:511];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .mov      (mov),
        .rw       (rw),
        .addr     (addr),
        .size     (size),
        .data_in  (data_in),
        .data_out (data_out),
        .moc      (moc),
        .err      (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour; updates the model memory for committed writes.
    function automatic exp_t model_access(input logic rd, input logic [8:0] a,
                                          input logic [1:0] sz, input logic [31:0] d);
        exp_t e;
        int   n;
        logic bad;
        n   = 1;
        bad = 1'b0;
        case (sz)
            2'b00: n = 1;
            2'b01: begin n = 2; bad = a[0]; end
            2'b10: begin n = 4; bad = (a[1:0] != 2'b00); end
            default: bad = 1'b1;
        endcase
        e.data = 32'h0;
        e.err  = bad;
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                if (rd) e.data = (e.data << 8) | {24'h0, model_mem[int'(a) + i]};
                else    model_mem[int'(a) + i] = d[8*(n-1-i) +: 8];
            end
        end
        return e;
    endfunction

    task automatic run_req(input logic rd, input logic [8:0] a, input logic [1:0] sz,
                           input logic [31:0] d, input int hold);
        exp_t e;
        int   cyc;
        @(negedge clk);
        mov = 1'b1; rw = rd; addr = a; size = sz; data_in = d;
        sb_q.push_back(model_access(rd, a, sz, d));
        @(posedge clk); #1;
        // scramble request inputs after capture; the DUT must ignore them
        rw = ~rd; addr = ~a; size = ~sz; data_in = ~d;
        cyc = 0;
        while (!moc && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("latency", cyc, 32'd4);
        e = sb_q.pop_front();
        check_val("data_out", data_out, e.data);
        check_val("err", {31'h0, err}, {31'h0, e.err});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_moc", {31'h0, moc}, 32'd1);
            check_val("hold_data", data_out, e.data);
        end
        @(negedge clk); mov = 1'b0;
        @(posedge clk); #1;
        check_val("moc_clear", {31'h0, moc}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset = 1'b0; mov = 1'b0; rw = 1'b0; addr = 9'h0; size = 2'b00; data_in = 32'h0;
        for (int i = 0; i < 512; i++) model_mem[i] = 8'h00;
        #12;
        check_val("rst_moc", {31'h0, moc}, 32'd0);
        check_val("rst_err", {31'h0, err}, 32'd0);
        check_val("rst_data", data_out, 32'h0);
        @(negedge clk); reset = 1'b1;

        // Clear the locations read later so model and DUT agree.
        run_req(1'b0, 9'h004, SZ_WORD, 32'h00000000, 0);
        run_req(1'b0, 9'h010, SZ_WORD, 32'h00000000, 0);

        run_req(1'b0, 9'h004, SZ_WORD, 32'hDEADBEEF, 0);
        run_req(1'b1, 9'h004, SZ_WORD, 32'h0, 0);
        run_req(1'b1, 9'h005, SZ_BYTE, 32'h0, 0);
        run_req(1'b1, 9'h006, SZ_HALF, 32'h0, 0);
        run_req(1'b0, 9'h006, SZ_WORD, 32'h12345678, 0);
        run_req(1'b1, 9'h004, SZ_WORD, 32'h0, 0);
        run_req(1'b1, 9'h008, SZ_RSVD, 32'h0, 0);
        run_req(1'b1, 9'h005, SZ_HALF, 32'h0, 0);
        run_req(1'b0, 9'h007, SZ_BYTE, 32'hFFFFFF5A, 0);
        run_req(1'b1, 9'h004, SZ_WORD, 32'h0, 0);
        run_req(1'b0, 9'h004, SZ_HALF, 32'hFFFF1234, 0);
        run_req(1'b1, 9'h004, SZ_WORD, 32'h0, 0);
        run_req(1'b0, 9'h1FC, SZ_WORD, 32'hCAFEF00D, 0);
        run_req(1'b1, 9'h1FC, SZ_WORD, 32'h0, 0);
        run_req(1'b1, 9'h1FF, SZ_BYTE, 32'h0, 0);

        // Abort one cycle into WAIT: no moc, no write.
        @(negedge clk);
        mov = 1'b1; rw = 1'b0; addr = 9'h1FC; size = SZ_WORD; data_in = 32'h11111111;
        @(posedge clk);
        @(negedge clk); mov = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_val("abort_moc", {31'h0, moc}, 32'd0);
        end
        run_req(1'b1, 9'h1FC, SZ_WORD, 32'h0, 0);

        // Hold mov high for 5 cycles in DONE.
        run_req(1'b1, 9'h004, SZ_WORD, 32'h0, 5);

        // mov falls on the edge that completes ACCESS: commit and one-cycle moc.
        @(negedge clk);
        mov = 1'b1; rw = 1'b0; addr = 9'h010; size = SZ_WORD; data_in = 32'hA5A5A5A5;
        e = model_access(1'b0, 9'h010, SZ_WORD, 32'hA5A5A5A5);
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk); mov = 1'b0;
        @(posedge clk); #1;
        check_val("late_moc", {31'h0, moc}, 32'd1);
        check_val("late_err", {31'h0, err}, {31'h0, e.err});
        @(posedge clk); #1;
        check_val("late_moc_clr", {31'h0, moc}, 32'd0);
        run_req(1'b1, 9'h010, SZ_WORD, 32'h0, 0);

        // Asynchronous reset while results are held in DONE.
        @(negedge clk);
        mov = 1'b1; rw = 1'b1; addr = 9'h004; size = SZ_WORD;
        repeat (5) @(posedge clk);
        #1;
        check_val("pre_rst_moc", {31'h0, moc}, 32'd1);
        #2; reset = 1'b0; #1;
        check_val("arst_moc", {31'h0, moc}, 32'd0);
        check_val("arst_data", data_out, 32'h0);
        check_val("arst_err", {31'h0, err}, 32'd0);
        mov = 1'b0;
        @(negedge clk); reset = 1'b1;

        // Reset mid-WAIT on a write: memory must be unchanged.
        @(negedge clk);
        mov = 1'b1; rw = 1'b0; addr = 9'h1FC; size = SZ_WORD; data_in = 32'h00000000;
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b0; #1;
        check_val("wrst_moc", {31'h0, moc}, 32'd0);
        mov = 1'b0;
        @(negedge clk); reset = 1'b1;
        run_req(1'b1, 9'h1FC, SZ_WORD, 32'h0, 0);
        run_req(1'b1, 9'h004, SZ_WORD, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
